kbd_event_arbiter: RTL

Sequences keyboard events from the SPI link and the non-ADB keyboard front-end into the single keyboard-event stream consumed by the keyboard/mouse serial emitter. It replaces the fixed-priority SPI-over-non-ADB selection. That selection silently drops the non-ADB word when both sources strobe together, and it cannot stall. This block instead gives each source a small FIFO and grants the sources round-robin. It presents one event at a time on a valid/ready handshake and enforces a minimum idle gap between events, so the emitter's serial protocol is never overrun.

---
 rtl/kbd_event_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/kbd_event_arbiter.sv
// -----------------------------------------------------------------------------
// kbd_event_arbiter
//
// Merges keyboard events from the SPI link and the non-ADB keyboard front-end
// into the single event stream consumed by the keyboard/mouse serial emitter.
// Each source gets its own small FIFO so simultaneous strobes are never lost.
// The sources are granted round-robin, and one event at a time is presented on
// a valid/ready handshake. After every accepted event a minimum idle gap is
// enforced so the emitter's serial protocol is never overrun.
//
// Ports:
//   clk             system clock (only clock)
//   reset           asynchronous, active-high reset
//   spi_data/valid  SPI keyboard event + single-cycle strobe
//   nonadb_data/valid  non-ADB keyboard event + single-cycle strobe
//   out_data        granted event, held stable while out_valid is high
//   out_src         source of out_data (0 = SPI, 1 = non-ADB)
//   out_valid       event available
//   out_ready       consumer accepts (transfer on out_valid && out_ready)
//   spi_overflow    sticky: an SPI event was dropped
//   nonadb_overflow sticky: a non-ADB event was dropped
//   ovf_clear       clears both overflow flags (a same-cycle drop wins)
//   spi_level       SPI FIFO occupancy
//   nonadb_level    non-ADB FIFO occupancy
// -----------------------------------------------------------------------------
module kbd_event_arbiter #(
    parameter int DATA_W     = 17,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          spi_data,
    input  logic                       spi_valid,
    input  logic [DATA_W-1:0]          nonadb_data,
    input  logic                       nonadb_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_src,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       spi_overflow,
    output logic                       nonadb_overflow,
    input  logic                       ovf_clear,
    output logic [$clog2(DEPTH+1)-1:0] spi_level,
    output logic [$clog2(DEPTH+1)-1:0] nonadb_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    // Counter runs GAP_CYCLES-1 down to 0, i.e. exactly GAP_CYCLES cycles in GAP.
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_GAP
    } state_t;

    // Index 0 = SPI, index 1 = non-ADB; matches the out_src encoding.
    logic [DATA_W-1:0] src_data  [2];
    logic [1:0]        src_valid;
    logic [DATA_W-1:0] head_data [2];
    logic [LVL_W-1:0]  level     [2];
    logic [1:0]        ovf;
    logic [1:0]        pop;

    assign src_data[0] = spi_data;
    assign src_data[1] = nonadb_data;
    assign src_valid   = {nonadb_valid, spi_valid};

    // -------------------------------------------------------------------------
    // Per-source FIFOs
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [LVL_W-1:0]  level_reg;
            logic [LVL_W-1:0]  level_next;
            logic              ovf_reg;
            logic              push;
            logic              drop;

            // A full FIFO still accepts a word when its head leaves in the
            // same cycle; the slot being written is the one being read out.
            assign push = src_valid[gi] && ((level_reg != FULL_LVL) || pop[gi]);
            assign drop = src_valid[gi] && !push;

            always_comb begin
                level_next = level_reg;
                case ({push, pop[gi]})
                    2'b10:   level_next = level_reg + 1'b1;
                    2'b01:   level_next = level_reg - 1'b1;
                    default: level_next = level_reg;
                endcase
            end

            // Storage needs no reset: reset empties the FIFO through the pointers.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= src_data[gi];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    level_reg <= level_next;
                    // A new drop takes priority over a simultaneous clear.
                    if (drop) begin
                        ovf_reg <= 1'b1;
                    end else if (ovf_clear) begin
                        ovf_reg <= 1'b0;
                    end
                end
            end

            assign head_data[gi] = mem[rd_ptr_reg];
            assign level[gi]     = level_reg;
            assign ovf[gi]       = ovf_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Grant / present / gap sequencer
    // -------------------------------------------------------------------------
    state_t            state_reg,      state_next;
    logic [DATA_W-1:0] out_data_reg,   out_data_next;
    logic              out_src_reg,    out_src_next;
    logic              last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]  gap_cnt_reg,    gap_cnt_next;
    logic              grant_sel;
    logic              spi_ne;
    logic              nonadb_ne;

    assign spi_ne    = (level[0] != '0);
    assign nonadb_ne = (level[1] != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            out_data_reg   <= '0;
            out_src_reg    <= 1'b0;
            last_grant_reg <= 1'b1;   // SPI wins the first contention
            gap_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            out_data_reg   <= out_data_next;
            out_src_reg    <= out_src_next;
            last_grant_reg <= last_grant_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        out_data_next   = out_data_reg;
        out_src_next    = out_src_reg;
        last_grant_next = last_grant_reg;
        gap_cnt_next    = gap_cnt_reg;
        pop             = 2'b00;
        grant_sel       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (spi_ne || nonadb_ne) begin
                    // Contention alternates; otherwise the only non-empty source wins.
                    if (spi_ne && nonadb_ne) begin
                        grant_sel = ~last_grant_reg;
                    end else begin
                        grant_sel = nonadb_ne;
                    end
                    out_data_next   = head_data[grant_sel];
                    out_src_next    = grant_sel;
                    last_grant_next = grant_sel;
                    pop[grant_sel]  = 1'b1;
                    state_next      = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_cnt_next = GAP_LOAD;
                        state_next   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // out_valid depends only on registered state, never on out_ready.
    assign out_valid       = (state_reg == ST_PRESENT);
    assign out_data        = out_data_reg;
    assign out_src         = out_src_reg;
    assign spi_overflow    = ovf[0];
    assign nonadb_overflow = ovf[1];
    assign spi_level       = level[0];
    assign nonadb_level    = level[1];

endmodule
